alarme_sequenciador: RTL



---
 rtl/alarme_sequenciador.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alarme_sequenciador.sv
// Alarm escalation sequencer: arm, grace, warning, full alarm and snooze states
// driven by presence, link status and an acknowledge button, with tick-based timers.
module alarme_sequenciador #(
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned GRACE_TICKS  = 200,
   parameter int unsigned WARN_TICKS   = 300,
   parameter int unsigned SNOOZE_TICKS = 600,
   parameter int unsigned BLINK_DIV    = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       presenca,
   input  logic       link_ok,
   input  logic       button,
   output logic [2:0] saida,
   output logic [2:0] estado,
   output logic       alarm
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      GRACE  = 3'd2,
      WARN   = 3'd3,
      ALARM  = 3'd4,
      SNOOZE = 3'd5
   } state_t;

   localparam logic [23:0] TICK_LAST   = 24'(TICK_DIV - 1);
   localparam logic [25:0] BLINK_LAST  = 26'(BLINK_DIV - 1);
   localparam logic [15:0] GRACE_LOAD  = 16'(GRACE_TICKS);
   localparam logic [15:0] WARN_LOAD   = 16'(WARN_TICKS);
   localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_TICKS);

   state_t      state;
   state_t      state_nxt;
   logic        entering;

   logic        pres_q;
   logic        link_q;

   logic        btn_s1;
   logic        btn_s2;
   logic        btn_prev;
   logic [1:0]  sync_fill;
   logic        press;

   logic [23:0] presc;
   logic        tick;
   logic [15:0] timer;
   logic [15:0] timer_nxt;
   logic        expiry;

   logic [25:0] blink_cnt;
   logic [25:0] blink_cnt_nxt;
   logic        blink;
   logic        blink_nxt;

   logic [2:0]  saida_nxt;
   logic        alarm_nxt;

   // Until the synchronizer has refilled after reset the edge register is held
   // high, so a button held through reset release never looks like a new rise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_s1    <= 1'b0;
         btn_s2    <= 1'b0;
         btn_prev  <= 1'b1;
         sync_fill <= '0;
         press     <= 1'b0;
      end else begin
         btn_s1    <= button;
         btn_s2    <= btn_s1;
         sync_fill <= {sync_fill[0], 1'b1};
         btn_prev  <= sync_fill[1] ? btn_s2 : 1'b1;
         press     <= btn_s2 & ~btn_prev;
      end
   end

   assign tick   = (presc == TICK_LAST);
   assign expiry = tick && (timer == 16'd1);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pres_q) state_nxt = ARMED;
         end
         ARMED: begin
            if (!pres_q)      state_nxt = IDLE;
            else if (!link_q) state_nxt = GRACE;
         end
         GRACE: begin
            if (!pres_q)     state_nxt = IDLE;
            else if (link_q) state_nxt = ARMED;
            else if (expiry) state_nxt = WARN;
         end
         WARN: begin
            if (!pres_q)     state_nxt = IDLE;
            else if (link_q) state_nxt = ARMED;
            else if (press)  state_nxt = SNOOZE;
            else if (expiry) state_nxt = ALARM;
         end
         ALARM: begin
            // a presence dropout must not silence an active alarm
            if (link_q)     state_nxt = ARMED;
            else if (press) state_nxt = SNOOZE;
         end
         SNOOZE: begin
            if (!pres_q)     state_nxt = IDLE;
            else if (link_q) state_nxt = ARMED;
            else if (expiry) state_nxt = WARN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign entering = (state_nxt != state);

   always_comb begin
      timer_nxt = timer;
      if (entering) begin
         case (state_nxt)
            GRACE:   timer_nxt = GRACE_LOAD;
            WARN:    timer_nxt = WARN_LOAD;
            SNOOZE:  timer_nxt = SNOOZE_LOAD;
            default: timer_nxt = '0;
         endcase
      end else if (tick && (timer != 16'd0)) begin
         timer_nxt = timer - 16'd1;
      end
   end

   always_comb begin
      blink_nxt     = blink;
      blink_cnt_nxt = blink_cnt + 26'd1;
      if (entering) begin
         blink_nxt     = 1'b1;
         blink_cnt_nxt = '0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_nxt     = ~blink;
         blink_cnt_nxt = '0;
      end
   end

   // Outputs decode the next state so they register on the same edge as it.
   always_comb begin
      saida_nxt = '0;
      alarm_nxt = 1'b0;
      case (state_nxt)
         ARMED:  saida_nxt = 3'b001;
         GRACE:  saida_nxt = {2'b00, blink_nxt};
         WARN: begin
            saida_nxt = {1'b1, blink_nxt, 1'b0};
            alarm_nxt = 1'b1;
         end
         ALARM: begin
            saida_nxt = 3'b110;
            alarm_nxt = 1'b1;
         end
         SNOOZE: saida_nxt = 3'b100;
         default: saida_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pres_q    <= 1'b0;
         link_q    <= 1'b0;
         presc     <= '0;
         timer     <= '0;
         blink     <= 1'b0;
         blink_cnt <= '0;
         saida     <= '0;
         estado    <= '0;
         alarm     <= 1'b0;
      end else begin
         state     <= state_nxt;
         pres_q    <= presenca;
         link_q    <= link_ok;
         presc     <= (entering || tick) ? '0 : presc + 24'd1;
         timer     <= timer_nxt;
         blink     <= blink_nxt;
         blink_cnt <= blink_cnt_nxt;
         saida     <= saida_nxt;
         estado    <= state_nxt;
         alarm     <= alarm_nxt;
      end
   end

endmodule
